// File: rtl/fwd_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the ID-stage forwarding scoreboard.
//   sb_entry_t : one tracked in-flight register write {valid, rd, cnt}.
//                An entry can be forwarded once cnt has reached zero.
//   SEL_RF     : forward-select code meaning "read the register file".
//   LAT_ALU/LAT_LOAD : issue latencies of the two producer classes.
//   clog2      : constant-function log2 used for derived widths.
// The entry field widths match the default REG_AW / LAT_W of the top level.
// ----------------------------------------------------------------------------
package fwd_pkg;

    localparam int SB_RD_W  = 5;
    localparam int SB_CNT_W = 2;

    localparam int SEL_RF   = 0;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    typedef struct packed {
        logic                valid;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_src_lookup.sv
// ----------------------------------------------------------------------------
// fwd_src_lookup
// Combinational priority search of the scoreboard for one ID-stage source.
//   entries  : scoreboard, index 0 = youngest (ID/EX)
//   srcUse   : the source is consumed in ID this cycle
//   srcReg   : source register address
//   sel      : SEL_RF, or k+1 to forward from pipeline position k
//   stallReq : the youngest matching producer has not produced its value yet
// ----------------------------------------------------------------------------
module fwd_src_lookup
    import fwd_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int SELW   = 2
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic              srcUse,
    input  logic [REG_AW-1:0] srcReg,
    output logic [SELW-1:0]   sel,
    output logic              stallReq
);

    logic found;

    // Only the youngest match counts: once found, older (possibly ready)
    // entries hold a stale value and must not be selected.
    always_comb begin
        sel      = SELW'(SEL_RF);
        stallReq = 1'b0;
        found    = 1'b0;
        if (srcUse && (srcReg != '0)) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && entries[k].valid && (entries[k].rd == srcReg)) begin
                    found = 1'b1;
                    if (entries[k].cnt == '0) begin
                        sel = SELW'(k + 1);
                    end else begin
                        stallReq = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// ----------------------------------------------------------------------------
// branch_fwd_scoreboard
// Hazard / forwarding controller for operands consumed in ID (branch compare,
// jr/jalr target). In-flight register writes shift through DEPTH positions
// with a ready countdown; each source picks the youngest ready producer or
// stalls ID.
//   clk, rst_n   : clock, asynchronous active-low reset
//   hold         : back-end stall, scoreboard frozen (counters still run)
//   iss_valid    : an instruction leaves ID this cycle; it is accepted only
//                  when stall is low, otherwise a bubble enters ID/EX
//   iss_wr/iss_rd/iss_lat : its register write and result latency
//   src_use/src_reg : per-source use flag and packed register addresses
//   fwd_sel      : per-source forward select (0 = register file)
//   stall        : hold PC and IF/ID, insert bubble
//   stall_cycles : saturating count of stalled cycles
//   hazard_err   : sticky flag, stall run exceeded MAX_STALL cycles
// ----------------------------------------------------------------------------
module branch_fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int NUM_SRC   = 2,
    parameter  int REG_AW    = 5,
    parameter  int DEPTH     = 3,
    parameter  int LAT_W     = 2,
    parameter  int MAX_STALL = 15,
    localparam int SELW      = clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      iss_valid,
    input  logic                      iss_wr,
    input  logic [REG_AW-1:0]         iss_rd,
    input  logic [LAT_W-1:0]          iss_lat,
    input  logic [NUM_SRC-1:0]        src_use,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cycles,
    output logic                      hazard_err
);

    localparam int               RUN_W     = clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

    sb_entry_t          sb [DEPTH];
    logic [NUM_SRC-1:0] stallReq;
    logic               issWrites;
    logic [15:0]        stallCnt;
    logic [RUN_W-1:0]   runCnt;
    logic               hazErr;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_lookup #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .SELW   (SELW)
        ) u_lookup (
            .entries  (sb),
            .srcUse   (src_use[i]),
            .srcReg   (src_reg[i*REG_AW +: REG_AW]),
            .sel      (fwd_sel[i*SELW +: SELW]),
            .stallReq (stallReq[i])
        );
    end

    assign stall = |stallReq;

    // r0 writes are never tracked; a stalled ID forces a bubble.
    assign issWrites = iss_valid & iss_wr & (iss_rd != '0) & ~stall;

    // The entry entering ID/EX keeps its full latency; older entries count
    // down as they move one position further.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else if (!hold) begin
            sb[0] <= '{valid: issWrites, rd: iss_rd, cnt: iss_lat};
            for (int k = 1; k < DEPTH; k++) begin
                sb[k].valid <= sb[k-1].valid;
                sb[k].rd    <= sb[k-1].rd;
                sb[k].cnt   <= (sb[k-1].cnt == '0) ? '0 : sb[k-1].cnt - SB_CNT_W'(1);
            end
        end
    end

    // Statistics and watchdog keep running while hold freezes the scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            runCnt   <= '0;
            hazErr   <= 1'b0;
        end else if (stall) begin
            if (stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (runCnt != RUN_LIMIT) begin
                runCnt <= runCnt + RUN_W'(1);
            end
            // The run reaches MAX_STALL+1 on this edge.
            if (runCnt >= RUN_LIMIT - RUN_W'(1)) begin
                hazErr <= 1'b1;
            end
        end else begin
            runCnt <= '0;
        end
    end

    assign stall_cycles = stallCnt;
    assign hazard_err   = hazErr;

endmodule
